soc_arb2: RTL and testbench

//  Two-master round-robin arbiter for the SOC valid/ready bus. Shares one slave

---
 rtl/soc_arb2.sv | 170 +++++++++++++++++
 tb/tb_soc_arb2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/soc_arb2.sv
// soc_arb2 - two-master round-robin arbiter for the SOC valid/ready bus.
//
// Shares one slave port between two masters. A grant lasts for exactly one
// transaction (s_vld & s_rdy). Request and payload are passed straight through
// combinationally; only the ownership state is registered. A watchdog ends
// transactions on which the slave never answers, because the bus itself has no
// timeout.
//
// Ports
//   clk, srst                  clock, synchronous active-high reset
//   m0_* / m1_*                master ports: vld/addr/we/wdat in, rdy/rdat out
//   s_*                        slave port: vld/addr/we/wdat out, rdy/rdat in
//   err_to                     sticky, set by the first timeout
//   err_mst                    master index of the most recent timeout
//   to_cnt                     saturating count of timeouts
module soc_arb2 #(
    parameter int            AW      = 32,
    parameter int            DW      = 32,
    parameter int            WW      = 4,
    parameter int            TO_CYC  = 256,
    parameter logic [DW-1:0] TO_RDAT = DW'(32'hDEAD_BEEF)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          m0_vld,
    output logic          m0_rdy,
    input  logic [AW-1:0] m0_addr,
    input  logic [WW-1:0] m0_we,
    input  logic [DW-1:0] m0_wdat,
    output logic [DW-1:0] m0_rdat,
    input  logic          m1_vld,
    output logic          m1_rdy,
    input  logic [AW-1:0] m1_addr,
    input  logic [WW-1:0] m1_we,
    input  logic [DW-1:0] m1_wdat,
    output logic [DW-1:0] m1_rdat,
    output logic          s_vld,
    input  logic          s_rdy,
    output logic [AW-1:0] s_addr,
    output logic [WW-1:0] s_we,
    output logic [DW-1:0] s_wdat,
    input  logic [DW-1:0] s_rdat,
    output logic          err_to,
    output logic          err_mst,
    output logic [7:0]    to_cnt
);

    // Wide enough to hold TO_CYC itself; one bit when the watchdog is off.
    localparam int WCW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             err_to_q, err_to_d;
    logic             err_mst_q, err_mst_d;
    logic [7:0]       to_cnt_q, to_cnt_d;

    logic             own;
    logic             sel;
    logic             req_vld;
    logic             to_hit;

    assign own     = (state_q == OWN0) || (state_q == OWN1);
    assign sel     = (state_q == OWN1);
    assign req_vld = sel ? m1_vld : m0_vld;

    // A slave answering in the limit cycle wins: that is a normal completion.
    assign to_hit  = (TO_CYC != 0) && own && req_vld && !s_rdy &&
                     (wait_q == WCW'(TO_CYC));

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            wait_q    <= '0;
            err_to_q  <= 1'b0;
            err_mst_q <= 1'b0;
            to_cnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            err_to_q  <= err_to_d;
            err_mst_q <= err_mst_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wait_d    = wait_q;
        err_to_d  = err_to_q;
        err_mst_d = err_mst_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (m0_vld && m1_vld) begin
                    // Tie: the master that did not have the last grant wins.
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_vld) begin
                    state_d = OWN0;
                end else if (m1_vld) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!req_vld) begin
                    // Master withdrew its request: drop the grant, keep last.
                    state_d = IDLE;
                    wait_d  = '0;
                end else if (s_rdy) begin
                    state_d = IDLE;
                    last_d  = sel;
                    wait_d  = '0;
                end else if (to_hit) begin
                    state_d   = IDLE;
                    last_d    = sel;
                    wait_d    = '0;
                    err_to_d  = 1'b1;
                    err_mst_d = sel;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end else if (TO_CYC != 0) begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_vld   = 1'b0;
        s_addr  = '0;
        s_we    = '0;
        s_wdat  = '0;
        m0_rdy  = 1'b0;
        m1_rdy  = 1'b0;
        m0_rdat = '0;
        m1_rdat = '0;
        if (own) begin
            // On timeout the slave request is pulled and the master is
            // acknowledged with the poison read value instead.
            s_vld  = req_vld && !to_hit;
            s_addr = sel ? m1_addr : m0_addr;
            s_we   = sel ? m1_we   : m0_we;
            s_wdat = sel ? m1_wdat : m0_wdat;
            if (sel) begin
                m1_rdy  = s_rdy || to_hit;
                m1_rdat = to_hit ? TO_RDAT : s_rdat;
            end else begin
                m0_rdy  = s_rdy || to_hit;
                m0_rdat = to_hit ? TO_RDAT : s_rdat;
            end
        end
    end

    assign err_to  = err_to_q;
    assign err_mst = err_mst_q;
    assign to_cnt  = to_cnt_q;

endmodule

// File: tb/tb_soc_arb2.sv
// Directed bench for soc_arb2 with a short watchdog (TO_CYC=4).
module tb_soc_arb2;

    logic        clk;
    logic        srst;
    logic        m0_vld, m0_rdy, m1_vld, m1_rdy;
    logic [31:0] m0_addr, m0_wdat, m0_rdat, m1_addr, m1_wdat, m1_rdat;
    logic [3:0]  m0_we, m1_we, s_we;
    logic        s_vld, s_rdy;
    logic [31:0] s_addr, s_wdat, s_rdat;
    logic        err_to, err_mst;
    logic [7:0]  to_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    soc_arb2 #(
        .AW(32), .DW(32), .WW(4), .TO_CYC(4), .TO_RDAT(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .srst(srst),
        .m0_vld(m0_vld), .m0_rdy(m0_rdy), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_wdat(m0_wdat), .m0_rdat(m0_rdat),
        .m1_vld(m1_vld), .m1_rdy(m1_rdy), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_wdat(m1_wdat), .m1_rdat(m1_rdat),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_addr(s_addr), .s_we(s_we),
        .s_wdat(s_wdat), .s_rdat(s_rdat),
        .err_to(err_to), .err_mst(err_mst), .to_cnt(to_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        srst = 1; m0_vld = 0; m1_vld = 0; s_rdy = 0;
        m0_addr = 0; m0_we = 0; m0_wdat = 0; m1_addr = 0; m1_we = 0; m1_wdat = 0;
        s_rdat = 0;

        // 1: reset, then first tie goes to m0
        step(); step(); #1;
        check("rst_m0_rdy", m0_rdy, 0);
        check("rst_m1_rdy", m1_rdy, 0);
        check("rst_s_vld", s_vld, 0);
        check("rst_err_to", err_to, 0);
        check("rst_to_cnt", to_cnt, 0);
        check("rst_err_mst", err_mst, 0);
        srst = 0; m0_vld = 1; m0_addr = 32'h10; m1_vld = 1; m1_addr = 32'h20;
        #1;
        check("tie_idle_s_vld", s_vld, 0);
        step(); #1;
        check("tie_s_vld", s_vld, 1);
        check("tie_s_addr_m0", s_addr, 32'h10);
        check("tie_m1_rdy", m1_rdy, 0);
        m0_vld = 0; m1_vld = 0;
        step(); #1;
        check("abort_s_vld", s_vld, 0);
        check("abort_err_to", err_to, 0);

        // 2: single m0 write, slave ready immediately
        m0_vld = 1; m0_addr = 32'h100; m0_we = 4'hF; m0_wdat = 32'hA5A5_0001;
        #1;
        check("wr_idle_rdy", m0_rdy, 0);
        step(); s_rdy = 1; #1;
        check("wr_s_vld", s_vld, 1);
        check("wr_s_addr", s_addr, 32'h100);
        check("wr_s_we", s_we, 4'hF);
        check("wr_s_wdat", s_wdat, 32'hA5A5_0001);
        check("wr_m0_rdy", m0_rdy, 1);
        check("wr_m1_rdy", m1_rdy, 0);
        step(); m0_vld = 0; s_rdy = 0; m0_we = 0; #1;
        check("wr_done_rdy", m0_rdy, 0);
        check("wr_done_s_vld", s_vld, 0);

        // 4: m1 read with 3 slave wait cycles, m0 held off
        m1_vld = 1; m1_addr = 32'h40; m1_we = 0;
        #1;
        step(); m0_vld = 1; m0_addr = 32'h50; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            check("rd_wait_s_vld", s_vld, 1);
            check("rd_wait_s_addr", s_addr, 32'h40);
            check("rd_wait_m1_rdy", m1_rdy, 0);
            check("rd_wait_m0_rdy", m0_rdy, 0);
        end
        step(); s_rdy = 1; s_rdat = 32'h1234_5678; #1;
        check("rd_m1_rdy", m1_rdy, 1);
        check("rd_m1_rdat", m1_rdat, 32'h1234_5678);
        check("rd_m0_rdy", m0_rdy, 0);
        check("rd_m0_rdat", m0_rdat, 0);
        step(); m1_vld = 0; s_rdy = 0; #1;

        // 3: both requesting, slave always ready -> m0,m1,m0,m1 with bubbles
        m0_vld = 1; m0_addr = 32'h200; m1_vld = 1; m1_addr = 32'h300; s_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            #1;
            if (i % 2 == 0) begin
                check("rr_bubble_s_vld", s_vld, 0);
            end else if (i % 4 == 1) begin
                check("rr_m0_s_addr", s_addr, 32'h200);
                check("rr_m0_rdy", m0_rdy, 1);
                check("rr_m0_other", m1_rdy, 0);
            end else begin
                check("rr_m1_s_addr", s_addr, 32'h300);
                check("rr_m1_rdy", m1_rdy, 1);
                check("rr_m1_other", m0_rdy, 0);
            end
        end
        step(); m0_vld = 0; m1_vld = 0; s_rdy = 0; #1;

        // 5: m0 read, slave never ready -> timeout after 4 wait cycles
        m0_vld = 1; m0_we = 0; m0_addr = 32'h60;
        #1;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("to_wait_s_vld", s_vld, 1);
            check("to_wait_m0_rdy", m0_rdy, 0);
        end
        step(); #1;
        check("to_s_vld", s_vld, 0);
        check("to_m0_rdy", m0_rdy, 1);
        check("to_m0_rdat", m0_rdat, 32'hDEAD_BEEF);
        check("to_err_before", err_to, 0);
        step(); m0_vld = 0; #1;
        check("to_err_to", err_to, 1);
        check("to_err_mst", err_mst, 0);
        check("to_cnt_1", to_cnt, 1);
        check("to_idle_s_vld", s_vld, 0);

        // slave answering in the limit cycle is a normal completion
        m1_vld = 1; m1_addr = 32'h70;
        #1;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("lim_wait_m1_rdy", m1_rdy, 0);
        end
        step(); s_rdy = 1; s_rdat = 32'hCAFE_0001; #1;
        check("lim_s_vld", s_vld, 1);
        check("lim_m1_rdy", m1_rdy, 1);
        check("lim_m1_rdat", m1_rdat, 32'hCAFE_0001);
        step(); m1_vld = 0; s_rdy = 0; #1;
        check("lim_to_cnt", to_cnt, 1);
        check("lim_err_mst", err_mst, 0);

        // 6: reset during an OWN1 wait
        m1_vld = 1; m1_addr = 32'h80;
        #1;
        step(); step(); #1;
        check("r6_s_vld_before", s_vld, 1);
        srst = 1;
        step(); #1;
        check("r6_s_vld", s_vld, 0);
        check("r6_m1_rdy", m1_rdy, 0);
        check("r6_err_to", err_to, 0);
        check("r6_to_cnt", to_cnt, 0);
        srst = 0; m0_vld = 1; m0_addr = 32'h90;
        step(); #1;
        check("r6_tie_s_vld", s_vld, 1);
        check("r6_tie_s_addr", s_addr, 32'h90);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
